serial_subtractor: RTL and testbench

- Bit-serial subtractor, the inverse counterpart of the team's half_adder.
- Loads two WIDTH-bit operands and computes diff = a - b LSB-first, one bit per clock.
- The datapath is a single full-subtractor cell (diff bit = x^y^bin; bout = (~x&y) | (~(x^y)&bin)) with a borrow flip-flop.
- Used as a low-area arithmetic unit behind a start/done handshake.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// A single full-subtractor cell plus a borrow flip-flop walks WIDTH bits.
// The start/done handshake is driven by an IDLE -> SHIFT -> DONE FSM.
// diff/bout update only when a result completes, so they hold the last
// result while the next operation is shifting.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_a_q;
    logic [WIDTH-1:0] sreg_b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             dbit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

`ifdef SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        dbit_d   = sreg_a_q[0] ^ sreg_b_q[0] ^ borrow_q;
        borrow_d = (~sreg_a_q[0] & sreg_b_q[0]) |
                   (~(sreg_a_q[0] ^ sreg_b_q[0]) & borrow_q);
        res_d    = {dbit_d, res_q[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sreg_a_q <= a;
                        sreg_b_q <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef SUB_OVF_EN
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sreg_a_q <= sreg_a_q >> 1;
                    sreg_b_q <= sreg_b_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        // Last bit: publish the complete result with done.
                        diff_q  <= res_d;
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SUB_OVF_EN
                        // dbit_d is the MSB of the finished difference.
                        ovf_q   <= (a_msb_q != b_msb_q) && (dbit_d != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed cases plus
// random operands compared against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r > 127) || (r < -128);
    endfunction

    // Launch one operation, then measure latency and busy length.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0; busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " busy_cycles"}, busy_cnt, 8);
        check({tag, " diff"}, diff, ref_diff(ta, tbv));
        check({tag, " bout"}, bout, ref_bout(ta, tbv));
`ifdef SUB_OVF_EN
        check({tag, " ovf"}, ovf, ref_ovf(ta, tbv));
`endif
        @(negedge clk);
        check({tag, " done_single"}, done, 0);
        check({tag, " diff_hold"}, diff, ref_diff(ta, tbv));
        $display("[TB] op %s a=%02h b=%02h diff=%02h bout=%0d lat=%0d", tag, ta, tbv, diff, bout, lat);
    endtask

    initial begin
        int n_done;
        int last_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset diff", diff, 0);
        check("reset bout", bout, 0);
`ifdef SUB_OVF_EN
        check("reset ovf", ovf, 0);
`endif

        do_op(8'h05, 8'h03, "05-03");
        do_op(8'h03, 8'h05, "03-05");
        do_op(8'h00, 8'hFF, "00-FF");
        do_op(8'h5A, 8'h5A, "5A-5A");
        do_op(8'h80, 8'h01, "80-01");
        do_op(8'h7F, 8'hFF, "7F-FF");

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
            if (k == 4) start = 1'b0;
            if (done) begin
                n_done++;
                check("ignore_start diff", diff, 8'h0F);
            end
            @(negedge clk);
        end
        check("ignore_start done_count", n_done, 1);
        $display("[TB] op ignore_start dones=%0d diff=%02h", n_done, diff);

        // Reset in the 4th SHIFT cycle abandons the operation.
        @(negedge clk);
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset diff", diff, 0);
        check("midreset bout", bout, 0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("midreset no_done", n_done, 0);
        $display("[TB] op midreset dones=%0d", n_done);
        do_op(8'h05, 8'h03, "after_reset");

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h09; b = 8'h04; start = 1'b1;
        n_done = 0; last_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("b2b diff", diff, 8'h05);
                if (n_done > 1) check("b2b interval", k - last_done, 10);
                last_done = k;
            end
        end
        start = 1'b0;
        check("b2b done_count", n_done, 3);
        $display("[TB] op back_to_back dones=%0d", n_done);
        repeat (12) @(negedge clk);

        // Random operands against the model.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) rb = ra;
            do_op(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
